// File: rtl/fsk_demod_pkg.sv
// Shared constants and helpers for the FSK demodulator.
//   CNT_W            : width of the half-period interval counter
//   DEF_*            : default timing parameters in clk cycles
//   sym_e / classify : half-period to symbol decision
package fsk_demod_pkg;

  localparam int unsigned CNT_W           = 9;
  localparam int unsigned DEF_HALF_MIN    = 100;
  localparam int unsigned DEF_HALF_THRESH = 166;
  localparam int unsigned DEF_HALF_MAX    = 255;
  localparam int unsigned DEF_TIMEOUT     = 400;

  typedef enum logic [1:0] {
    SYM_SPACE   = 2'd0,
    SYM_MARK    = 2'd1,
    SYM_INVALID = 2'd2
  } sym_e;

  // Short half-periods are mark, long ones space; anything outside the
  // accepted window (including a saturated counter) is rejected.
  function automatic sym_e classify(input logic [CNT_W-1:0] h,
                                    input int unsigned      hmin,
                                    input int unsigned      hthresh,
                                    input int unsigned      hmax);
    int unsigned hv;
    hv = 32'(h);
    if (h == '1)
      return SYM_INVALID;
    if (hv >= hmin && hv < hthresh)
      return SYM_MARK;
    if (hv >= hthresh && hv <= hmax)
      return SYM_SPACE;
    return SYM_INVALID;
  endfunction

endpackage

// File: rtl/fsk_edge_sync.sv
// Synchronizes the asynchronous FSK carrier and flags transitions.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   fsk_in     : asynchronous square-wave carrier
//   edge_pulse : one-cycle pulse on either carrier polarity change
module fsk_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic fsk_in,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= fsk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator: measures carrier half-periods, classifies each as
// mark/space/invalid and updates the output only when two consecutive
// valid half-periods agree. Loss of carrier forces the output low.
//   clk      : system clock, 100 MHz nominal
//   rst      : synchronous active-high reset
//   fsk_in   : asynchronous square-wave FSK carrier
//   data_out : registered demodulated bit
module fsk_demodulator
  import fsk_demod_pkg::*;
#(
  parameter int unsigned HALF_MIN    = DEF_HALF_MIN,
  parameter int unsigned HALF_THRESH = DEF_HALF_THRESH,
  parameter int unsigned HALF_MAX    = DEF_HALF_MAX,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic fsk_in,
  output logic data_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic             edge_pulse;
  logic [CNT_W-1:0] cnt;
  logic             last_sym;
  logic             last_vld;
  sym_e             sym;
  logic             sym_bit;
  logic             timeout;

  fsk_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .fsk_in     (fsk_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    sym     = classify(cnt, HALF_MIN, HALF_THRESH, HALF_MAX);
    sym_bit = (sym == SYM_MARK);
    // cnt passes TIMEOUT only once per idle stretch and then parks at
    // saturation, so this fires a single time.
    timeout = !edge_pulse && (cnt == TIMEOUT_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last_sym <= 1'b0;
      last_vld <= 1'b0;
      data_out <= 1'b0;
    end else begin
      if (edge_pulse)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + 1'b1;

      if (edge_pulse && sym != SYM_INVALID) begin
        if (last_vld && last_sym == sym_bit)
          data_out <= sym_bit;
        last_sym <= sym_bit;
        last_vld <= 1'b1;
      end else if (timeout) begin
        data_out <= 1'b0;
        last_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_demodulator.sv
// Scoreboard bench for fsk_demodulator. Stimulus toggles fsk_in on
// falling clk edges and queues the expected data_out transitions
// (cycle + value) and steady-level checkpoints; the monitor compares
// every observed data_out change and checkpoint against those queues.
module tb_fsk_demodulator;

  typedef struct {
    int    cyc;
    logic  val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic fsk_in;
  logic data_out;

  int   cyc = 0;
  bit   done = 1'b0;
  exp_t evq[$];
  exp_t lvq[$];

  fsk_demodulator #(
    .HALF_MIN    (100),
    .HALF_THRESH (166),
    .HALF_MAX    (255),
    .TIMEOUT     (400)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fsk_in   (fsk_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toggle now; if expv >= 0 the toggle completes an agreeing pair and
  // data_out must change 3 cycles later. Then hold for n cycles.
  task automatic half(input int n, input int expv, input string nm);
    exp_t e;
    fsk_in = ~fsk_in;
    if (expv >= 0) begin
      e.cyc  = cyc + 3;
      e.val  = expv[0];
      e.name = nm;
      evq.push_back(e);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic level(input logic v, input string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.val  = v;
    e.name = nm;
    lvq.push_back(e);
  endtask

  // Stimulus
  initial begin
    exp_t e;
    rst    = 1'b1;
    fsk_in = 1'b0;
    repeat (3) @(negedge clk);
    level(1'b0, "reset_state");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Mark tone: first interval after reset is short (invalid), then two 148s.
    half(148, -1, "");
    half(148, -1, "");
    half(148, 1, "mark_lock");
    repeat (3) half(148, -1, "");
    level(1'b1, "mark_steady");

    // Switch to space: first toggle ends a 148 interval, then two 184s.
    half(184, -1, "");
    half(184, -1, "");
    half(184, 0, "space_lock");
    repeat (2) half(184, -1, "");
    level(1'b0, "space_steady");

    // 20-cycle glitch splitting a 184 half-period: 82/20/82 all invalid.
    half(82, -1, "");
    half(20, -1, "");
    half(82, -1, "");
    repeat (3) half(184, -1, "");
    level(1'b0, "glitch_hold");

    // Lone 150-cycle interval inside a space stream.
    half(150, -1, "");
    repeat (3) half(184, -1, "");
    level(1'b0, "odd_interval");

    // Re-lock to mark, then carrier loss for 1000 cycles.
    half(148, -1, "");
    half(148, -1, "");
    fsk_in = ~fsk_in;
    e.cyc = cyc + 3;   e.val = 1'b1; e.name = "mark_relock"; evq.push_back(e);
    e.cyc = cyc + 403; e.val = 1'b0; e.name = "timeout";     evq.push_back(e);
    repeat (1000) @(negedge clk);
    level(1'b0, "timeout_hold");

    // Mark again (first interval is saturated, invalid), then reset mid-tone.
    half(148, -1, "");
    half(148, -1, "");
    half(148, 1, "pre_reset_lock");
    half(148, -1, "");
    repeat (70) @(negedge clk);
    rst = 1'b1;
    e.cyc = cyc + 1; e.val = 1'b0; e.name = "mid_reset"; evq.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    half(148, -1, "");
    half(148, -1, "");
    half(148, 1, "post_reset_relock");
    half(148, -1, "");
    level(1'b1, "post_reset_steady");

    repeat (20) @(negedge clk);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    int   n_checks;
    int   n_fail;
    logic prev;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    prev     = 1'b0;
    forever begin
      @(negedge clk);
      if (data_out !== prev) begin
        n_checks++;
        if (evq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: data_out=%0b at cycle %0d, required no change (stay %0b)",
                   data_out, cyc, prev);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cyc || data_out !== e.val) begin
            n_fail++;
            $display("FAIL %s: data_out=%0b at cycle %0d, required %0b at cycle %0d",
                     e.name, data_out, cyc, e.val, e.cyc);
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL %s: data_out stayed %0b through cycle %0d, required %0b at cycle %0d",
                 e.name, data_out, cyc, e.val, e.cyc);
      end
      prev = data_out;

      while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
        e = lvq.pop_front();
        n_checks++;
        if (data_out !== e.val) begin
          n_fail++;
          $display("FAIL %s: data_out=%0b at cycle %0d, required %0b",
                   e.name, data_out, cyc, e.val);
        end
      end

      if (done || cyc > 20000) begin
        n_checks++;
        if (!done) begin
          n_fail++;
          $display("FAIL watchdog: stimulus unfinished at cycle %0d, required completion by 20000", cyc);
        end else if (evq.size() != 0 || lvq.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d events and %0d checkpoints pending, required 0",
                   evq.size(), lvq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule

// File: doc/fsk_demodulator.md
FSK_DEMODULATOR -- requirements
Module: fsk_demodulator

Interface
REQ-001 Parameter HALF_MIN, 100: shortest accepted half-period in clk cycles; shorter intervals are glitches.
REQ-002 Parameter HALF_THRESH, 166: mark/space decision boundary in clk cycles.
REQ-003 Parameter HALF_MAX, 255: longest accepted half-period in clk cycles.
REQ-004 Parameter TIMEOUT, 400: clk cycles without an input edge before carrier loss is declared.
REQ-005 clk  input  1  single system clock, 100 MHz nominal; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fsk_in  input  1  asynchronous square-wave FSK carrier: space (0) toggles every 184 clk, mark (1) toggles every 148 clk.
REQ-008 data_out  output  1  registered demodulated bit.

Function
REQ-009 fsk_in SHALL pass through a 2-flop synchronizer (s1, s2), then a third flop s3; edge = s2 XOR s3; both polarities count.
REQ-010 9-bit interval counter cnt SHALL load 1 on an edge cycle; otherwise it SHALL increment, saturating at 511.
REQ-011 On an edge cycle, measured half-period H SHALL equal cnt's value before the load.
REQ-012 Classification: HALF_MIN <= H < HALF_THRESH -> symbol 1; HALF_THRESH <= H <= HALF_MAX -> symbol 0; any other H -> invalid.
REQ-013 Invalid H SHALL be ignored for decisions; cnt still restarts.
REQ-014 Registers last_sym (1 bit) and last_vld (1 bit) SHALL hold the previous valid symbol.
REQ-015 On each valid H: if last_vld=1 and last_sym equals the new symbol, data_out SHALL take that symbol on the same clock edge.
REQ-016 Every valid H SHALL update last_sym to the new symbol and set last_vld=1.
REQ-017 data_out SHALL change only under REQ-015, REQ-018 or reset; a single odd half-period never flips it.
REQ-018 Timeout: when cnt == TIMEOUT and no edge is present that cycle, data_out SHALL go to 0 and last_vld to 0 on the same edge.
REQ-019 Timeout SHALL fire once per idle period; cnt saturation at 511 SHALL NOT re-trigger it.
REQ-020 Latency: data_out SHALL update 3 clk cycles after the fsk_in transition that completes the second agreeing half-period (2 sync + 1 edge/decide register).
REQ-021 Width rule: H compares as unsigned 9-bit; saturated 511 is always invalid.

Reset
REQ-022 While rst=1 at a clk edge: s1, s2, s3, data_out, last_sym, last_vld SHALL become 0, and cnt SHALL become 0.
REQ-023 Reset mid-tone SHALL discard any partial measurement.
REQ-024 The first edge after reset SHALL yield H = (cycles since reset release) and be classified normally.

Structure
REQ-025 Package fsk_demod_pkg SHALL hold HALF_MIN, HALF_THRESH, HALF_MAX, TIMEOUT defaults and the 9-bit counter width constant.
REQ-026 Sub-module fsk_edge_sync SHALL contain s1/s2/s3 and the edge output.
REQ-027 fsk_demodulator SHALL contain the counter, classifier, agreement and timeout logic.

Verification
REQ-028 Reset, then fsk_in toggling every 148 clk -> data_out=1 three cycles after the second toggle following the first full interval; then steady at 1.
REQ-029 Tone switch 148 -> 184 clk half-period -> data_out falls to 0 after two consecutive 184-cycle intervals, never earlier.
REQ-030 Glitch: 20-clk pulse inserted in a 184-clk tone -> both short intervals invalid; data_out stays 0.
REQ-031 Single 150-clk interval inside a 184-clk stream -> data_out unchanged (agreement rule).
REQ-032 fsk_in held constant 1000 clk while data_out=1 -> data_out=0 exactly when cnt reaches 400; no further change.
REQ-033 rst asserted one cycle mid-mark-tone -> next edge all registers 0; data_out returns to 1 after two fresh valid 148-clk intervals.
